// File: rtl/rx71_word_align.sv
// Word-alignment controller for the 7:1 LVDS receive path.
// Compares the deserialized clock-lane word against the expected pattern,
// requests bit slips (ALIGNWD) until it matches, then declares lock and
// forwards the data-lane words with a valid flag. Single clock domain (SCLK).
module rx71_word_align #(
  parameter logic [6:0] CLK_PATTERN   = 7'b1100011,
  parameter int         NUM_LANES     = 4,
  parameter int         SETTLE_CYCLES = 4,   // 2..15
  parameter int         LOCK_COUNT    = 16,  // 1..255
  parameter int         LOSS_COUNT    = 4,   // 1..15
  parameter int         MAX_SLIPS     = 7    // 1..15
) (
  input  logic                     SCLK,
  input  logic                     RST,
  input  logic                     START,
  input  logic [6:0]               CLK_WORD,
  input  logic [7*NUM_LANES-1:0]   DATA_IN,
  output logic                     ALIGNWD,
  output logic [7*NUM_LANES-1:0]   DATA_OUT,
  output logic                     DATA_VALID,
  output logic                     LOCKED,
  output logic                     ALIGN_ERR,
  output logic [3:0]               SLIP_CNT
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_CHECK  = 3'd2,
    ST_SLIP   = 3'd3,
    ST_LOCK   = 3'd4,
    ST_ERROR  = 3'd5
  } state_t;

  // The settle counter counts down to zero, so it is loaded with N-1 to
  // give exactly SETTLE_CYCLES cycles in SETTLE.
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [7:0] LOCK_LAST   = 8'(LOCK_COUNT - 1);
  localparam logic [3:0] LOSS_LAST   = 4'(LOSS_COUNT - 1);
  localparam logic [3:0] SLIP_MAX    = 4'(MAX_SLIPS);

  state_t     state;
  logic [3:0] settle_cnt;
  logic [7:0] match_cnt;
  logic [3:0] miss_cnt;
  logic       clk_match;

  assign clk_match = (CLK_WORD == CLK_PATTERN);

  // Alignment FSM with registered status outputs and slip request.
  // NOTE: every register here uses non-blocking assignment so all branches
  // see the pre-edge values of state and counters, matching hardware.
  always_ff @(posedge SCLK) begin
    if (RST) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      match_cnt  <= '0;
      miss_cnt   <= '0;
      SLIP_CNT   <= '0;
      ALIGNWD    <= 1'b0;
      LOCKED     <= 1'b0;
      ALIGN_ERR  <= 1'b0;
    end else begin
      // Slip request is a single-cycle pulse; only the CHECK->SLIP transition raises it.
      ALIGNWD <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (START) begin
            state      <= ST_SETTLE;
            settle_cnt <= SETTLE_LOAD;
            SLIP_CNT   <= '0;
            match_cnt  <= '0;
          end
        end

        ST_SETTLE: begin
          if (settle_cnt == 4'd0) begin
            state <= ST_CHECK;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end

        ST_CHECK: begin
          if (clk_match) begin
            match_cnt <= match_cnt + 8'd1;
            if (match_cnt == LOCK_LAST) begin
              state    <= ST_LOCK;
              LOCKED   <= 1'b1;
              miss_cnt <= '0;
            end
          end else begin
            match_cnt <= '0;
            if (SLIP_CNT == SLIP_MAX) begin
              state     <= ST_ERROR;
              ALIGN_ERR <= 1'b1;
            end else begin
              state   <= ST_SLIP;
              ALIGNWD <= 1'b1;
            end
          end
        end

        ST_SLIP: begin
          SLIP_CNT   <= SLIP_CNT + 4'd1;
          settle_cnt <= SETTLE_LOAD;
          state      <= ST_SETTLE;
        end

        ST_LOCK: begin
          // START and a final lock-loss miss collapse into one realign.
          if (START || (!clk_match && (miss_cnt == LOSS_LAST))) begin
            state      <= ST_SETTLE;
            LOCKED     <= 1'b0;
            settle_cnt <= SETTLE_LOAD;
            SLIP_CNT   <= '0;
            match_cnt  <= '0;
            miss_cnt   <= '0;
          end else if (clk_match) begin
            miss_cnt <= '0;
          end else begin
            miss_cnt <= miss_cnt + 4'd1;
          end
        end

        ST_ERROR: begin
          if (START) begin
            state      <= ST_SETTLE;
            ALIGN_ERR  <= 1'b0;
            settle_cnt <= SETTLE_LOAD;
            SLIP_CNT   <= '0;
            match_cnt  <= '0;
          end
        end

        default: begin
          state     <= ST_IDLE;
          LOCKED    <= 1'b0;
          ALIGN_ERR <= 1'b0;
        end
      endcase
    end
  end

  // Data path: one-cycle register stage; valid follows LOCKED by one cycle
  // so it lines up with the registered data.
  always_ff @(posedge SCLK) begin
    if (RST) begin
      DATA_OUT   <= '0;
      DATA_VALID <= 1'b0;
    end else begin
      DATA_OUT   <= DATA_IN;
      DATA_VALID <= LOCKED;
    end
  end

endmodule

// File: tb/tb_rx71_word_align.sv
// Directed testbench for rx71_word_align with a small deserializer model
// that rotates the clock-lane word once per ALIGNWD pulse.
module tb_rx71_word_align;

  localparam logic [6:0] PAT = 7'b1100011;
  localparam int         NL  = 4;

  logic            SCLK;
  logic            RST;
  logic            START;
  logic [6:0]      CLK_WORD;
  logic [7*NL-1:0] DATA_IN;
  logic            ALIGNWD;
  logic [7*NL-1:0] DATA_OUT;
  logic            DATA_VALID;
  logic            LOCKED;
  logic            ALIGN_ERR;
  logic [3:0]      SLIP_CNT;

  int passed = 0;
  int total  = 0;

  // Bench-side stimulus and deserializer model state
  logic [6:0] bench_word;
  logic       model_on;
  logic       model_clr;
  logic [6:0] model_start;
  logic [6:0] rot_word;
  logic       aw_prev;
  int         cyc;
  int         last_rise;
  int         rise_cnt;
  int         hi_cnt;
  int         gap_bad;

  rx71_word_align dut (
    .SCLK       (SCLK),
    .RST        (RST),
    .START      (START),
    .CLK_WORD   (CLK_WORD),
    .DATA_IN    (DATA_IN),
    .ALIGNWD    (ALIGNWD),
    .DATA_OUT   (DATA_OUT),
    .DATA_VALID (DATA_VALID),
    .LOCKED     (LOCKED),
    .ALIGN_ERR  (ALIGN_ERR),
    .SLIP_CNT   (SLIP_CNT)
  );

  initial SCLK = 1'b0;
  always #5 SCLK = ~SCLK;

  assign CLK_WORD = model_on ? rot_word : bench_word;

  // Deserializer model: one right-rotation per ALIGNWD cycle, plus pulse
  // counting and spacing measurement (expected spacing 6 cycles).
  always @(posedge SCLK) begin
    cyc <= cyc + 1;
    if (model_clr) begin
      rot_word  <= model_start;
      aw_prev   <= 1'b0;
      rise_cnt  <= 0;
      hi_cnt    <= 0;
      gap_bad   <= 0;
      last_rise <= 0;
    end else begin
      aw_prev <= ALIGNWD;
      if (ALIGNWD) begin
        hi_cnt   <= hi_cnt + 1;
        rot_word <= {rot_word[0], rot_word[6:1]};
      end
      if (ALIGNWD && !aw_prev) begin
        rise_cnt <= rise_cnt + 1;
        if (rise_cnt != 0 && (cyc - last_rise) != 6) gap_bad <= gap_bad + 1;
        last_rise <= cyc;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge SCLK);
    #1;
  endtask

  // Tick until the selected output goes high; n = ticks taken, -1 on timeout.
  task automatic wait_sig(input int which, input int max_ticks, output int n);
    logic hit;
    n = -1;
    for (int i = 1; i <= max_ticks; i++) begin
      tick();
      case (which)
        0:       hit = LOCKED;
        1:       hit = ALIGN_ERR;
        default: hit = ALIGNWD;
      endcase
      if (hit) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int bad;
    cyc         = 0;
    RST         = 1'b1;
    START       = 1'b0;
    DATA_IN     = '0;
    bench_word  = PAT;
    model_on    = 1'b0;
    model_clr   = 1'b1;
    model_start = PAT;

    // Reset state
    tick(); tick();
    check("rst_alignwd", ALIGNWD, 0);
    check("rst_locked", LOCKED, 0);
    check("rst_err", ALIGN_ERR, 0);
    check("rst_slipcnt", SLIP_CNT, 0);
    check("rst_dout_valid", {DATA_OUT, DATA_VALID}, 0);
    RST = 1'b0;
    tick();
    check("idle_locked", LOCKED, 0);

    // Clean lock: START at edge 0, LOCKED from edge 20, DATA_VALID from edge 21
    START = 1'b1;
    tick();
    START = 1'b0;
    bad = 0;
    for (int i = 1; i <= 19; i++) begin
      tick();
      if (LOCKED || ALIGNWD) bad++;
    end
    check("clean_prelock", bad, 0);
    tick();
    check("clean_locked_e20", LOCKED, 1);
    check("clean_valid_e20", DATA_VALID, 0);
    tick();
    check("clean_valid_e21", DATA_VALID, 1);
    check("clean_slipcnt", SLIP_CNT, 0);

    // Data passthrough while locked
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      DATA_IN = 28'h1234560 + 28'(i);
      tick();
      if (DATA_OUT !== 28'h1234560 + 28'(i) || DATA_VALID !== 1'b1) bad++;
    end
    check("data_passthru", bad, 0);
    DATA_IN = 28'h0ABCDEF;
    tick();
    check("data_value", DATA_OUT, 28'h0ABCDEF);

    // Hysteresis: 3 misses then a match keeps lock
    bench_word = 7'h00;
    tick(); tick(); tick();
    check("hyst_3miss", LOCKED, 1);
    bench_word = PAT;
    tick();
    check("hyst_match", LOCKED, 1);

    // Four consecutive misses drop lock and realign from SETTLE
    bench_word = 7'h00;
    tick(); tick(); tick();
    check("loss_3miss", LOCKED, 1);
    tick();
    bench_word = PAT;
    check("loss_locked", LOCKED, 0);
    check("loss_valid_lag", DATA_VALID, 1);
    check("loss_slipcnt", SLIP_CNT, 0);
    tick();
    check("loss_valid", DATA_VALID, 0);
    wait_sig(0, 40, n);
    check("loss_relock_ticks", n, 19);

    // Lock-loss miss coinciding with START: a single realign
    bench_word = 7'h00;
    tick(); tick(); tick();
    START = 1'b1;
    tick();
    START = 1'b0;
    bench_word = PAT;
    check("sim_unlocked", LOCKED, 0);
    wait_sig(0, 40, n);
    check("sim_relock_ticks", n, 20);

    // Three-slip alignment via the deserializer model
    model_start = 7'b0011110;
    model_on    = 1'b1;
    START       = 1'b1;
    tick();
    START     = 1'b0;
    model_clr = 1'b0;
    wait_sig(0, 80, n);
    check("slip3_lock_edge", n, 38);
    check("slip3_rises", rise_cnt, 3);
    check("slip3_width", hi_cnt, 3);
    check("slip3_gap", gap_bad, 0);
    check("slip3_slipcnt", SLIP_CNT, 3);

    // Slip exhaustion with an all-zero clock word
    model_clr   = 1'b1;
    model_start = 7'h00;
    START       = 1'b1;
    tick();
    START     = 1'b0;
    model_clr = 1'b0;
    wait_sig(1, 100, n);
    check("exh_err_edge", n, 47);
    check("exh_rises", rise_cnt, 7);
    check("exh_gap", gap_bad, 0);
    check("exh_slipcnt", SLIP_CNT, 7);
    check("exh_locked", LOCKED, 0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!ALIGN_ERR || SLIP_CNT !== 4'd7 || LOCKED || ALIGNWD) bad++;
    end
    check("exh_hold", bad, 0);

    // Recovery from ERROR with the correct pattern
    model_on   = 1'b0;
    bench_word = PAT;
    START      = 1'b1;
    tick();
    START = 1'b0;
    check("rec_err", ALIGN_ERR, 0);
    check("rec_slipcnt", SLIP_CNT, 0);
    wait_sig(0, 40, n);
    check("rec_lock_ticks", n, 20);

    // Reset during the SLIP cycle
    bench_word = 7'h00;
    START      = 1'b1;
    tick();
    START = 1'b0;
    wait_sig(2, 20, n);
    check("rstslip_pulse_ticks", n, 5);
    RST = 1'b1;
    tick();
    check("rstslip_alignwd", ALIGNWD, 0);
    check("rstslip_slipcnt", SLIP_CNT, 0);
    check("rstslip_outs", {DATA_OUT, DATA_VALID, LOCKED, ALIGN_ERR}, 0);
    RST        = 1'b0;
    bench_word = PAT;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (LOCKED || ALIGNWD || ALIGN_ERR) bad++;
    end
    check("rstslip_idle", bad, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
